// File: rtl/mult_div_pkg.sv
// ============================================================================
// Module      : mult_div_pkg
// Description : Shared op encodings, FSM state type and default width for the
//               iterative multiply/divide unit.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package mult_div_pkg;

    localparam int DEFAULT_WIDTH = 32;

    localparam logic [1:0] OP_MULTU = 2'b00;
    localparam logic [1:0] OP_MULT  = 2'b01;
    localparam logic [1:0] OP_DIVU  = 2'b10;
    localparam logic [1:0] OP_DIV   = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2
    } state_t;

endpackage

`default_nettype wire

// File: rtl/mult_div_step.sv
// ============================================================================
// Module      : mult_div_step
// Description : Combinational single iteration: shift-add multiply step or
//               restoring divide step on a 2*WIDTH working accumulator.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mult_div_step #(
    parameter int WIDTH = 32
) (
    input  logic               is_div,
    input  logic [2*WIDTH-1:0] acc,
    input  logic [WIDTH-1:0]   opnd,
    output logic [2*WIDTH-1:0] acc_next,
    output logic               q_bit
);

    logic [WIDTH:0]     w_sum;
    logic [WIDTH:0]     w_diff;
    logic [2*WIDTH-1:0] w_acc_mul;
    logic [2*WIDTH-1:0] w_acc_div;

    // Multiply: {partial product, remaining multiplier bits}, LSB first.
    assign w_sum     = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opnd} : '0);
    assign w_acc_mul = {w_sum, acc[WIDTH-1:1]};

    // Divide: {partial remainder, dividend/quotient}; the quotient bit is
    // left as zero here and merged by the caller through q_bit.
    assign w_diff    = acc[2*WIDTH-1:WIDTH-1] - {1'b0, opnd};
    assign w_acc_div = w_diff[WIDTH] ? {acc[2*WIDTH-2:0], 1'b0}
                                     : {w_diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};

    assign acc_next = is_div ? w_acc_div : w_acc_mul;
    assign q_bit    = is_div & ~w_diff[WIDTH];

endmodule

`default_nettype wire

// File: rtl/mult_div_unit.sv
// ============================================================================
// Module      : mult_div_unit
// Description : Fixed-latency iterative MULT/MULTU/DIV/DIVU engine writing the
//               architectural HI/LO registers, with MTHI/MTLO write ports.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mult_div_unit
    import mult_div_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             hi_we,
    input  logic             lo_we,
    input  logic [WIDTH-1:0] wdata,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    state_t             r_state;
    state_t             w_state_next;
    logic [CNT_W-1:0]   r_cnt;
    logic [2*WIDTH-1:0] r_acc;
    logic [WIDTH-1:0]   r_opnd;
    logic [WIDTH-1:0]   r_a_orig;
    logic               r_is_div;
    logic               r_neg_res;
    logic               r_neg_rem;
    logic               r_dbz;
    logic [WIDTH-1:0]   r_hi;
    logic [WIDTH-1:0]   r_lo;
    logic               r_done;
    logic               r_dbz_pulse;

    logic               w_is_signed;
    logic               w_a_neg;
    logic               w_b_neg;
    logic [WIDTH-1:0]   w_a_mag;
    logic [WIDTH-1:0]   w_b_mag;
    logic [2*WIDTH-1:0] w_acc_next;
    logic               w_q_bit;
    logic [2*WIDTH-1:0] w_prod;
    logic [WIDTH-1:0]   w_quo;
    logic [WIDTH-1:0]   w_rem;

    assign w_is_signed = op[0];
    assign w_a_neg     = w_is_signed & A[WIDTH-1];
    assign w_b_neg     = w_is_signed & B[WIDTH-1];
    assign w_a_mag     = w_a_neg ? (~A + 1'b1) : A;
    assign w_b_mag     = w_b_neg ? (~B + 1'b1) : B;

    mult_div_step #(
        .WIDTH    (WIDTH)
    ) u_step (
        .is_div   (r_is_div),
        .acc      (r_acc),
        .opnd     (r_opnd),
        .acc_next (w_acc_next),
        .q_bit    (w_q_bit)
    );

    assign w_prod = r_neg_res ? (~r_acc + 1'b1) : r_acc;
    assign w_quo  = r_neg_res ? (~r_acc[WIDTH-1:0] + 1'b1) : r_acc[WIDTH-1:0];
    assign w_rem  = r_neg_rem ? (~r_acc[2*WIDTH-1:WIDTH] + 1'b1) : r_acc[2*WIDTH-1:WIDTH];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    if (start) w_state_next = RUN;
            RUN:     if (r_cnt == '0) w_state_next = FIX;
            FIX:     w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt       <= '0;
            r_acc       <= '0;
            r_opnd      <= '0;
            r_a_orig    <= '0;
            r_is_div    <= 1'b0;
            r_neg_res   <= 1'b0;
            r_neg_rem   <= 1'b0;
            r_dbz       <= 1'b0;
            r_hi        <= '0;
            r_lo        <= '0;
            r_done      <= 1'b0;
            r_dbz_pulse <= 1'b0;
        end else begin
            r_done      <= 1'b0;
            r_dbz_pulse <= 1'b0;
            case (r_state)
                IDLE: begin
                    // MTHI/MTLO land first; an accepted start's result overwrites later.
                    if (hi_we) r_hi <= wdata;
                    if (lo_we) r_lo <= wdata;
                    if (start) begin
                        r_cnt     <= CNT_W'(WIDTH - 1);
                        r_is_div  <= op[1];
                        r_neg_res <= w_a_neg ^ w_b_neg;
                        r_neg_rem <= w_a_neg;
                        r_dbz     <= op[1] & (B == '0);
                        r_a_orig  <= A;
                        r_opnd    <= op[1] ? w_b_mag : w_a_mag;
                        r_acc     <= op[1] ? {{WIDTH{1'b0}}, w_a_mag}
                                           : {{WIDTH{1'b0}}, w_b_mag};
                    end
                end
                RUN: begin
                    r_acc <= w_acc_next | {{(2*WIDTH-1){1'b0}}, w_q_bit};
                    if (r_cnt != '0) r_cnt <= r_cnt - 1'b1;
                end
                FIX: begin
                    r_done <= 1'b1;
                    if (!r_is_div) begin
                        r_hi <= w_prod[2*WIDTH-1:WIDTH];
                        r_lo <= w_prod[WIDTH-1:0];
                    end else if (r_dbz) begin
                        r_hi        <= r_a_orig;
                        r_lo        <= '1;
                        r_dbz_pulse <= 1'b1;
                    end else begin
                        r_hi <= w_rem;
                        r_lo <= w_quo;
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy        = (r_state != IDLE);
    assign done        = r_done;
    assign div_by_zero = r_dbz_pulse;
    assign hi          = r_hi;
    assign lo          = r_lo;

endmodule

`default_nettype wire

// File: tb/tb_mult_div_unit.sv
// ============================================================================
// Module      : tb_mult_div_unit
// Description : Self-checking bench for mult_div_unit against an arithmetic
//               reference model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mult_div_unit;

    localparam logic [1:0] C_MULTU = 2'b00;
    localparam logic [1:0] C_MULT  = 2'b01;
    localparam logic [1:0] C_DIVU  = 2'b10;
    localparam logic [1:0] C_DIV   = 2'b11;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [1:0]  op;
    logic [31:0] A;
    logic [31:0] B;
    logic        hi_we;
    logic        lo_we;
    logic [31:0] wdata;
    logic        busy;
    logic        done;
    logic        div_by_zero;
    logic [31:0] hi;
    logic [31:0] lo;

    int n_vec = 0;
    int n_err = 0;

    mult_div_unit #(
        .WIDTH       (32),
        .CNT_W       (6)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .op          (op),
        .A           (A),
        .B           (B),
        .hi_we       (hi_we),
        .lo_we       (lo_we),
        .wdata       (wdata),
        .busy        (busy),
        .done        (done),
        .div_by_zero (div_by_zero),
        .hi          (hi),
        .lo          (lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Architectural result of one operation, straight from the arithmetic rules.
    function automatic void model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] h, output logic [31:0] l, output logic z);
        longint      sa;
        longint      sb;
        logic [63:0] p;
        logic [63:0] q;
        logic [63:0] r;
        sa = o[0] ? longint'($signed(a)) : longint'({32'b0, a});
        sb = o[0] ? longint'($signed(b)) : longint'({32'b0, b});
        z  = 1'b0;
        if (!o[1]) begin
            if (o[0]) p = 64'(sa * sb);
            else      p = {32'b0, a} * {32'b0, b};
            h = p[63:32];
            l = p[31:0];
        end else if (b == 32'd0) begin
            z = 1'b1;
            h = a;
            l = 32'hFFFF_FFFF;
        end else begin
            q = 64'(sa / sb);
            r = 64'(sa % sb);
            h = r[31:0];
            l = q[31:0];
        end
    endfunction

    // Issues one op and waits (bounded) for done; lat counts edges after acceptance.
    task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                          output int lat, output int busy_cyc);
        @(negedge clk);
        start = 1'b1; op = o; A = a; B = b;
        @(negedge clk);
        start = 1'b0;
        lat = 0; busy_cyc = 0;
        while (!done && lat < 100) begin
            if (busy) busy_cyc++;
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic check_op(input string name, input logic [1:0] o, input logic [31:0] a,
                            input logic [31:0] b);
        int          lat;
        int          bc;
        logic [31:0] eh;
        logic [31:0] el;
        logic        ez;
        model(o, a, b, eh, el, ez);
        run_op(o, a, b, lat, bc);
        n_vec++;
        if (lat !== 33) begin
            $display("FAIL %s latency got %0d exp 33 (op=%0d a=%h b=%h)", name, lat, o, a, b); n_err++;
        end
        n_vec++;
        if (bc !== 33 || busy !== 1'b0) begin
            $display("FAIL %s busy cycles got %0d (busy now %b) exp 33 (0)", name, bc, busy); n_err++;
        end
        n_vec++;
        if (hi !== eh || lo !== el) begin
            $display("FAIL %s result hi=%h lo=%h exp hi=%h lo=%h (op=%0d a=%h b=%h)",
                     name, hi, lo, eh, el, o, a, b); n_err++;
        end
        n_vec++;
        if (div_by_zero !== ez) begin
            $display("FAIL %s div_by_zero got %b exp %b", name, div_by_zero, ez); n_err++;
        end
        @(negedge clk);
        n_vec++;
        if (done !== 1'b0 || div_by_zero !== 1'b0) begin
            $display("FAIL %s pulse width done=%b dbz=%b exp 0 0", name, done, div_by_zero); n_err++;
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0; start = 1'b0; op = 2'b00; A = '0; B = '0;
        hi_we = 1'b0; lo_we = 1'b0; wdata = '0;
        repeat (3) @(negedge clk);
        n_vec++;
        if ({busy, done, div_by_zero} !== 3'b000 || hi !== 32'd0 || lo !== 32'd0) begin
            $display("FAIL reset_state busy=%b done=%b dbz=%b hi=%h lo=%h exp all 0",
                     busy, done, div_by_zero, hi, lo); n_err++;
        end
        rst_n = 1'b1;
    endtask

    task automatic test_multu;
        check_op("multu_max", C_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        n_vec++;
        if (hi !== 32'hFFFF_FFFE || lo !== 32'h0000_0001) begin
            $display("FAIL multu_max_const hi=%h lo=%h exp fffffffe 00000001", hi, lo); n_err++;
        end
    endtask

    task automatic test_mult_div;
        check_op("mult_neg", C_MULT, 32'hFFFF_FFFD, 32'd7);
        n_vec++;
        if (hi !== 32'hFFFF_FFFF || lo !== 32'hFFFF_FFEB) begin
            $display("FAIL mult_neg_const hi=%h lo=%h exp ffffffff ffffffeb", hi, lo); n_err++;
        end
        check_op("div_neg", C_DIV, 32'hFFFF_FFF9, 32'd2);
        n_vec++;
        if (hi !== 32'hFFFF_FFFF || lo !== 32'hFFFF_FFFD) begin
            $display("FAIL div_neg_const hi=%h lo=%h exp ffffffff fffffffd", hi, lo); n_err++;
        end
        check_op("div_wrap", C_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
        n_vec++;
        if (hi !== 32'h0 || lo !== 32'h8000_0000) begin
            $display("FAIL div_wrap_const hi=%h lo=%h exp 00000000 80000000", hi, lo); n_err++;
        end
        check_op("div_zero_signed", C_DIV, 32'hFFFF_FF00, 32'd0);
    endtask

    task automatic test_divu;
        check_op("divu_100_7", C_DIVU, 32'd100, 32'd7);
        n_vec++;
        if (hi !== 32'd2 || lo !== 32'd14) begin
            $display("FAIL divu_100_7_const hi=%h lo=%h exp 2 14", hi, lo); n_err++;
        end
        check_op("divu_by_zero", C_DIVU, 32'd5, 32'd0);
    endtask

    task automatic test_back_to_back;
        int k;
        @(negedge clk);
        start = 1'b1; op = C_MULTU; A = 32'd3; B = 32'd4;
        @(negedge clk);
        start = 1'b0; k = 0;
        repeat (5) begin @(negedge clk); k++; end
        start = 1'b1; op = C_DIVU; A = 32'd99; B = 32'd0;
        @(negedge clk);
        start = 1'b0; k++;
        while (!done && k < 100) begin @(negedge clk); k++; end
        n_vec++;
        if (k !== 33 || hi !== 32'd0 || lo !== 32'd12 || div_by_zero !== 1'b0) begin
            $display("FAIL b2b_ignored lat=%0d hi=%h lo=%h dbz=%b exp 33 0 c 0",
                     k, hi, lo, div_by_zero); n_err++;
        end
        // Start issued in the done cycle must be taken.
        start = 1'b1; op = C_MULTU; A = 32'd5; B = 32'd6;
        @(negedge clk);
        start = 1'b0;
        n_vec++;
        if (busy !== 1'b1 || done !== 1'b0) begin
            $display("FAIL b2b_accept busy=%b done=%b exp 1 0", busy, done); n_err++;
        end
        k = 0;
        while (!done && k < 100) begin @(negedge clk); k++; end
        n_vec++;
        if (k !== 33 || hi !== 32'd0 || lo !== 32'd30) begin
            $display("FAIL b2b_second lat=%0d hi=%h lo=%h exp 33 0 1e", k, hi, lo); n_err++;
        end
    endtask

    task automatic test_hilo_writes;
        int          k;
        logic [31:0] lo_prev;
        @(negedge clk);
        hi_we = 1'b1; wdata = 32'h1234_5678;
        @(negedge clk);
        hi_we = 1'b0;
        n_vec++;
        if (hi !== 32'h1234_5678) begin
            $display("FAIL mthi_idle hi=%h exp 12345678", hi); n_err++;
        end
        lo_prev = lo;
        @(negedge clk);
        start = 1'b1; op = C_MULTU; A = 32'd6; B = 32'd7;
        @(negedge clk);
        start = 1'b0; lo_we = 1'b1; wdata = 32'hDEAD_BEEF;
        @(negedge clk);
        lo_we = 1'b0;
        n_vec++;
        if (lo !== lo_prev) begin
            $display("FAIL mtlo_busy lo=%h exp %h", lo, lo_prev); n_err++;
        end
        k = 1;
        while (!done && k < 100) begin @(negedge clk); k++; end
        n_vec++;
        if (k !== 33 || lo !== 32'd42 || hi !== 32'd0) begin
            $display("FAIL mtlo_busy_result lat=%0d hi=%h lo=%h exp 33 0 2a", k, hi, lo); n_err++;
        end
        @(negedge clk);
        start = 1'b1; op = C_MULTU; A = 32'd2; B = 32'd2;
        hi_we = 1'b1; wdata = 32'h1234_5678;
        @(negedge clk);
        start = 1'b0; hi_we = 1'b0; k = 0;
        n_vec++;
        if (hi !== 32'h1234_5678 || busy !== 1'b1) begin
            $display("FAIL mthi_with_start hi=%h busy=%b exp 12345678 1", hi, busy); n_err++;
        end
        while (!done && k < 100) begin @(negedge clk); k++; end
        n_vec++;
        if (k !== 33 || hi !== 32'd0 || lo !== 32'd4) begin
            $display("FAIL mthi_with_start_result lat=%0d hi=%h lo=%h exp 33 0 4", k, hi, lo); n_err++;
        end
    endtask

    task automatic test_reset_mid_op;
        int k;
        @(negedge clk);
        hi_we = 1'b1; lo_we = 1'b1; wdata = 32'hA5A5_0F0F;
        @(negedge clk);
        hi_we = 1'b0; lo_we = 1'b0;
        start = 1'b1; op = C_DIVU; A = 32'd1000; B = 32'd7;
        @(negedge clk);
        start = 1'b0;
        repeat (10) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        n_vec++;
        if (busy !== 1'b0 || done !== 1'b0 || hi !== 32'd0 || lo !== 32'd0) begin
            $display("FAIL reset_mid_op busy=%b done=%b hi=%h lo=%h exp 0 0 0 0", busy, done, hi, lo);
            n_err++;
        end
        @(negedge clk);
        rst_n = 1'b1;
        k = 0;
        repeat (40) begin @(negedge clk); if (done) k++; end
        n_vec++;
        if (k !== 0) begin
            $display("FAIL reset_discard done seen %0d times exp 0", k); n_err++;
        end
        check_op("divu_after_reset", C_DIVU, 32'd9, 32'd3);
    endtask

    task automatic test_random;
        logic [1:0]  o;
        logic [31:0] a;
        logic [31:0] b;
        for (int i = 0; i < 40; i++) begin
            o = 2'($urandom_range(0, 3));
            a = $urandom;
            b = $urandom;
            case ($urandom_range(0, 7))
                0: b = 32'd0;
                1: b = 32'hFFFF_FFFF;
                2: a = 32'h8000_0000;
                3: b = 32'($urandom_range(1, 15));
                4: a = 32'($urandom_range(0, 255));
                default: ;
            endcase
            check_op("random", o, a, b);
        end
    endtask

    initial begin
        test_reset();
        test_multu();
        test_mult_div();
        test_divu();
        test_back_to_back();
        test_hilo_writes();
        test_random();
        test_reset_mid_op();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/mult_div_unit.md
Name: mult_div_unit

Overview:
- Iterative multiply/divide engine in the EX stage, beside the ALU. It replaces the ALU's combinational 16x16 multiply and divide paths.
- Operands come from the same ID/EX operand path that feeds the ALU: A = rs value, B = rt value.
- It computes MULT, MULTU, DIV and DIVU into architectural HI/LO registers, one bit per cycle.
- busy stalls the pipeline. The HI/LO outputs feed the MFHI/MFLO path into the ALU result mux.

Parameters:
- WIDTH, 32, operand width and width of each of HI and LO.
- CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > WIDTH.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  request a new operation; accepted only while busy=0
- op  in  2  00 MULTU, 01 MULT, 10 DIVU, 11 DIV; sampled with start
- A  in  WIDTH  multiplicand / dividend
- B  in  WIDTH  multiplier / divisor
- hi_we  in  1  MTHI write enable
- lo_we  in  1  MTLO write enable
- wdata  in  WIDTH  MTHI/MTLO data
- busy  out  1  operation in flight; the hazard unit stalls on it
- done  out  1  one-cycle pulse; HI/LO hold the new result
- div_by_zero  out  1  one-cycle pulse, coincident with done, for a divide with B==0
- hi  out  WIDTH  HI register
- lo  out  WIDTH  LO register

Behaviour:
- Reset (rst_n low, asynchronous, any state): state=IDLE, counter=0; hi, lo, busy, done, div_by_zero all 0. An in-flight operation is discarded.
- States: IDLE, RUN, FIX.
- IDLE -> RUN: on an edge with start=1.
  - Capture op, sign flags, |A| and |B|. Signed ops use two's-complement magnitude; unsigned ops take operands as is.
  - Load counter with WIDTH-1.
- RUN: one iteration per edge; the counter decrements. RUN -> FIX on the edge where counter==0, so RUN lasts exactly WIDTH edges.
- FIX -> IDLE on the next edge. That edge writes hi/lo and sets done=1 (and div_by_zero if applicable) for one cycle.
- Latency: start accepted at edge E0 -> result and done at edge E0+WIDTH+1 (33 for WIDTH=32). Latency is fixed for all ops and operands, with no early-out.
- busy=1 from E0 until edge E0+WIDTH+1, where it drops. A new start is legal in the done cycle.
- Multiply:
  - Shift-add on magnitudes into a 2*WIDTH accumulator.
  - FIX negates the 2*WIDTH product if the operand signs differ (signed op only).
  - hi = upper WIDTH bits, lo = lower WIDTH bits.
- Divide:
  - Restoring division, one quotient bit per cycle.
  - Signed op: quotient is negated if the signs differ; remainder takes the dividend's sign (truncation toward zero).
  - lo = quotient, hi = remainder.
  - DIV 0x80000000 / 0xFFFFFFFF gives lo=0x80000000, hi=0 (wraps, no trap).
- Divide by zero (B==0, DIV or DIVU):
  - Same latency as any other divide.
  - lo = all ones, hi = A unchanged (original signed value).
  - div_by_zero pulses with done.
- start while busy=1: ignored; op/A/B are not sampled.
- hi_we / lo_we:
  - With busy=0: write wdata at the edge; visible the next cycle.
  - With busy=1: dropped.
  - Same edge as an accepted start: the write applies; the later result overwrites it.
- done and div_by_zero are registered and never high for more than one consecutive cycle.
- hi and lo are stable during RUN and FIX. The working registers are separate from the architectural registers.

Decomposition:
- Package mult_div_pkg holds:
  - op encodings OP_MULTU, OP_MULT, OP_DIVU, OP_DIV;
  - state enum IDLE/RUN/FIX;
  - the default WIDTH.
- Sub-module mult_div_step: purely combinational single-iteration datapath.
  - Inputs: op class, accumulator/partial remainder, operand bit(s).
  - Outputs: next accumulator and next quotient bit.
- mult_div_unit owns the FSM, counter, sign handling, HI/LO and the handshake.

Test Plan:
- MULTU A=0xFFFFFFFF B=0xFFFFFFFF, start at E0 -> busy high for 33 cycles; done at E0+33; hi=0xFFFFFFFE, lo=0x00000001.
- MULT A=0xFFFFFFFD (-3) B=7 -> hi=0xFFFFFFFF, lo=0xFFFFFFEB. Then DIV A=0xFFFFFFF9 (-7) B=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF.
- DIVU A=100 B=7 -> lo=14, hi=2, div_by_zero=0. DIVU A=5 B=0 -> lo=0xFFFFFFFF, hi=5, div_by_zero=1 for exactly one cycle with done.
- Back-to-back:
  - MULTU 3*4 started; start with other operands pulsed at E0+5 -> ignored; result hi=0, lo=12.
  - New start in the done cycle -> accepted; busy stays high.
- Reset mid-op: drive rst_n low asynchronously at E0+10 of a DIVU -> busy, done, hi, lo all 0 immediately, before the next edge. After release, DIVU 9/3 -> lo=3, hi=0.
- HI/LO writes:
  - hi_we with wdata=0x12345678 while idle -> hi=0x12345678 the next cycle.
  - lo_we while busy -> lo unchanged.
  - hi_we coincident with start of MULTU 2*2 -> hi=0x12345678 during RUN, then hi=0 and lo=4 at done.
